// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment display bus interface.
package seg_display_pkg;

    // Bus handshake FSM encoding
    typedef enum logic [0:0] {
        StIdle,
        StAck
    } bus_state_e;

    // Default DATA register byte address; CTRL sits one word above it
    localparam logic [31:0] SEG_BASE_DEFAULT = 32'h0000_FF00;
    localparam logic [31:0] CTRL_OFFSET      = 32'd4;

    // CTRL register bit positions
    localparam int unsigned CTRL_ENA_BIT   = 0;
    localparam int unsigned CTRL_VALID_BIT = 1;
    localparam int unsigned CTRL_PEND_BIT  = 2;

    // Assemble the CTRL readback word from its status bits
    function automatic logic [31:0] ctrl_word(input logic ena, input logic valid,
                                              input logic pend);
        logic [31:0] w;
        w                 = '0;
        w[CTRL_ENA_BIT]   = ena;
        w[CTRL_VALID_BIT] = valid;
        w[CTRL_PEND_BIT]  = pend;
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan divider and 2-bit digit counter; frame_end marks the last digit's tick.
module seg_scan_timer #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic scan_tick,
    output logic frame_end
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;

    // Next-state for the divider and digit counters; they never stop
    always_comb begin
        scan_tick = (cnt_q == CntMax);
        frame_end = scan_tick && (digit_q == 2'd3);
        cnt_d     = scan_tick ? '0 : cnt_q + CntW'(1);
        digit_d   = scan_tick ? digit_q + 2'd1 : digit_q;
    end

    // Counter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/seg_display_bus_if.sv
// CPU bus slave for a 4-digit hex display. DATA writes are shadowed and only
// committed at frame end so the display never tears mid-scan.
// Optional macro SEG_READBACK_EN enables register readback.
module seg_display_bus_if
    import seg_display_pkg::*;
#(
    parameter logic [31:0] SEG_BASE = SEG_BASE_DEFAULT,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic [15:0] disp_data,
    output logic        disp_ena,
    output logic        disp_wr_valid,
    output logic        scan_tick
);

    bus_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic [15:0] disp_q, disp_d;
    logic        ena_q, ena_d;
    logic        valid_q, valid_d;

    logic hit_data, hit_ctrl, take, wr_data, wr_ctrl, commit, frame_end;
    logic unused_wdata;

    assign unused_wdata = ^bus_wdata[31:16];

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_tick (scan_tick),
        .frame_end (frame_end)
    );

    // Address decode; a transaction is taken only from idle on a hit
    always_comb begin
        hit_data = (bus_addr == SEG_BASE);
        hit_ctrl = (bus_addr == SEG_BASE + CTRL_OFFSET);
        take     = (state_q == StIdle) && (bus_we || bus_re) && (hit_data || hit_ctrl);
        wr_data  = take && bus_we && hit_data;
        wr_ctrl  = take && bus_we && hit_ctrl;
        commit   = frame_end && pending_q;
    end

    // FSM next state: one ack cycle per taken request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM output
    always_comb begin
        bus_ack = (state_q == StAck);
    end

    // Read data; writes win when both requests are high
    always_comb begin
        rdata_d = '0;
`ifdef SEG_READBACK_EN
        if (take && !bus_we) begin
            if (hit_data) rdata_d = {16'h0, disp_q};
            else          rdata_d = ctrl_word(ena_q, valid_q, pending_q);
        end
`endif
    end

    // Shadow/commit datapath; a write on the commit edge keeps pending set
    always_comb begin
        shadow_d  = wr_data ? bus_wdata[15:0] : shadow_q;
        pending_d = pending_q;
        if (commit)  pending_d = 1'b0;
        if (wr_data) pending_d = 1'b1;
        disp_d    = commit ? shadow_q : disp_q;
        valid_d   = valid_q | commit;
        ena_d     = wr_ctrl ? bus_wdata[0] : ena_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rdata_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
            ena_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            ena_q     <= ena_d;
            valid_q   <= valid_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign disp_data     = disp_q;
    assign disp_ena      = ena_q;
    assign disp_wr_valid = valid_q;

endmodule

// File: tb/tb_seg_display_bus_if.sv
// Directed bench for seg_display_bus_if with SCAN_DIV=4 (16-cycle frame).
module tb_seg_display_bus_if;
    import seg_display_pkg::*;

    localparam logic [31:0] Base = SEG_BASE_DEFAULT;
    localparam logic [31:0] Ctrl = SEG_BASE_DEFAULT + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_re, bus_ack;
    logic [15:0] disp_data;
    logic        disp_ena, disp_wr_valid, scan_tick;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [31:0] exp_rdata[$];
    logic [15:0] exp_disp[$];

    seg_display_bus_if #(
        .SEG_BASE (Base),
        .SCAN_DIV (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .disp_data     (disp_data),
        .disp_ena      (disp_ena),
        .disp_wr_valid (disp_wr_valid),
        .scan_tick     (scan_tick)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; counter value in a cycle is cyc % 4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge where cyc % 16 == m
    task automatic wait_mod(input int m);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc % 16 == m) break;
        end
        check("wait_bound", {31'b0, i < 40}, 32'd1);
    endtask

    // Issue one request at the current negedge and wait (bounded) for ack
    task automatic bus_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic re, input logic exp_ack,
                          input logic [31:0] exp_rd);
        int   n;
        logic seen;
        logic [31:0] want;
        seen = 1'b0;
        if (exp_ack) exp_rdata.push_back(exp_rd);
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_we    = we;
        bus_re    = re;
        for (n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (bus_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (exp_ack) begin
            check({tag, "_lat"}, n, 32'd1);
            if (seen) begin
                want = exp_rdata.pop_front();
                check({tag, "_rdata"}, bus_rdata, want);
            end
        end else begin
            check({tag, "_noack"}, {31'b0, seen}, 32'd0);
        end
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    initial begin
        int   ticks;
        logic [31:0] rb_ctrl, rb_data, rb_prio;
        logic [15:0] want;

`ifdef SEG_READBACK_EN
        rb_ctrl = 32'h0000_0002;
        rb_data = 32'h0000_1234;
        rb_prio = 32'h0;
`else
        rb_ctrl = 32'h0;
        rb_data = 32'h0;
        rb_prio = 32'h0;
`endif
        rst_n     = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, bus_ack}, 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_disp", {16'b0, disp_data}, 32'd0);
        check("rst_valid", {31'b0, disp_wr_valid}, 32'd0);
        check("rst_ena", {31'b0, disp_ena}, 32'd0);
        check("rst_tick", {31'b0, scan_tick}, 32'd0);
        rst_n = 1'b1;

        // Scan tick every 4th cycle
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("scan_tick", {31'b0, scan_tick}, {31'b0, (cyc % 4) == 3});
            if (scan_tick) ticks++;
        end
        check("tick_count", ticks, 32'd4);
        check("idle_disp", {16'b0, disp_data}, 32'd0);
        check("idle_valid", {31'b0, disp_wr_valid}, 32'd0);

        // DATA write commits only at frame end; upper bits ignored
        wait_mod(2);
        exp_disp.push_back(16'h1234);
        bus_op("wr1234", Base, 32'hABCD_1234, 1'b1, 1'b0, 1'b1, 32'h0);
        check("shadow_hidden", {16'b0, disp_data}, 32'd0);
        wait_mod(15);
        check("pre_frame_disp", {16'b0, disp_data}, 32'd0);
        check("pre_frame_valid", {31'b0, disp_wr_valid}, 32'd0);
        @(negedge clk);
        want = exp_disp.pop_front();
        check("commit1234", {16'b0, disp_data}, {16'b0, want});
        check("valid_set", {31'b0, disp_wr_valid}, 32'd1);

        // Readback (zero without the readback macro)
        wait_mod(2);
        bus_op("rd_ctrl", Ctrl, 32'h0, 1'b0, 1'b1, 1'b1, rb_ctrl);
        wait_mod(5);
        bus_op("rd_data", Base, 32'h0, 1'b0, 1'b1, 1'b1, rb_data);

        // Two writes in one frame: only the last commits
        wait_mod(2);
        bus_op("wr1111", Base, 32'h0000_1111, 1'b1, 1'b0, 1'b1, 32'h0);
        wait_mod(5);
        exp_disp.push_back(16'h2222);
        bus_op("wr2222", Base, 32'h0000_2222, 1'b1, 1'b0, 1'b1, 32'h0);
        wait_mod(15);
        check("hold1234", {16'b0, disp_data}, 32'h1234);
        @(negedge clk);
        want = exp_disp.pop_front();
        check("commit2222", {16'b0, disp_data}, {16'b0, want});

        // Write landing on the frame-end edge: old shadow commits, new one waits
        wait_mod(2);
        exp_disp.push_back(16'h3333);
        bus_op("wr3333", Base, 32'h0000_3333, 1'b1, 1'b0, 1'b1, 32'h0);
        wait_mod(15);
        exp_disp.push_back(16'h4444);
        bus_op("wr4444", Base, 32'h0000_4444, 1'b1, 1'b0, 1'b1, 32'h0);
        want = exp_disp.pop_front();
        check("commit3333", {16'b0, disp_data}, {16'b0, want});
        wait_mod(15);
        check("hold3333", {16'b0, disp_data}, 32'h3333);
        @(negedge clk);
        want = exp_disp.pop_front();
        check("commit4444", {16'b0, disp_data}, {16'b0, want});

        // Miss: no ack, no state change
        wait_mod(2);
        bus_op("wr_miss", Base + 32'd8, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);
        check("miss_ena", {31'b0, disp_ena}, 32'd0);
        wait_mod(1);
        check("miss_disp", {16'b0, disp_data}, 32'h4444);

        // CTRL write: enable visible in the ack cycle
        wait_mod(4);
        bus_op("wr_ctrl", Ctrl, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0);
        check("ena_set", {31'b0, disp_ena}, 32'd1);

        // Write wins over read when both are high
        wait_mod(8);
        bus_op("wr_prio", Ctrl, 32'h0000_0000, 1'b1, 1'b1, 1'b1, rb_prio);
        check("ena_clr", {31'b0, disp_ena}, 32'd0);

        // Reset in the middle of a transaction drops it
        wait_mod(10);
        bus_addr  = Base;
        bus_wdata = 32'h0000_5555;
        bus_we    = 1'b1;
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        bus_we = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", {31'b0, bus_ack}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_noack", {31'b0, bus_ack}, 32'd0);
        end
        check("post_rst_disp", {16'b0, disp_data}, 32'd0);
        check("post_rst_valid", {31'b0, disp_wr_valid}, 32'd0);
        check("sb_empty", exp_rdata.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_bus_if.md
SEG_DISPLAY_BUS_IF -- requirements
Module: seg_display_bus_if

Interface
REQ-001 SHALL have parameter SEG_BASE, default 32'h0000_FF00; byte address of the DATA register; the CTRL register is at SEG_BASE+4.
REQ-002 SHALL have parameter SCAN_DIV, default 50000; number of clk cycles per scan tick, legal range 2..2^20.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port bus_addr, input, 32 bits; CPU bus address.
REQ-006 SHALL have port bus_wdata, input, 32 bits; CPU write data.
REQ-007 SHALL have ports bus_we and bus_re, input, 1 bit each; write and read request levels, held until bus_ack.
REQ-008 SHALL have port bus_ack, output, 1 bit; one-cycle completion pulse.
REQ-009 SHALL have port bus_rdata, output, 32 bits; read data, valid in the bus_ack cycle.
REQ-010 SHALL have port disp_data, output, 16 bits; committed hex value (4 nibbles) sent to the display stage.
REQ-011 SHALL have port disp_ena, output, 1 bit; display enable level (CTRL bit 0).
REQ-012 SHALL have port disp_wr_valid, output, 1 bit; sticky flag meaning "a DATA write has been committed since reset"; it feeds the display stage's write-valid input.
REQ-013 SHALL have port scan_tick, output, 1 bit; one-cycle strobe every SCAN_DIV cycles, used by the display stage as its digit-advance enable.

Function
REQ-014 SHALL implement a bus FSM with states IDLE, ACK, and a transition IDLE->ACK when (bus_we|bus_re) and the address hits DATA or CTRL; ACK->IDLE is unconditional.
REQ-015 SHALL assert bus_ack only in ACK, giving exactly 1 cycle of latency from request sampled to ack.
REQ-016 SHALL leave bus_ack low and keep the FSM in IDLE when a request misses both addresses.
REQ-017 SHALL give priority to write when bus_we and bus_re are both high.
REQ-018 SHALL, on a DATA write, capture bus_wdata[15:0] into a shadow register and set a pending flag at the IDLE->ACK edge; bits [31:16] are ignored.
REQ-019 SHALL, on a CTRL write, load bus_wdata[0] into disp_ena at the IDLE->ACK edge, with no shadowing.
REQ-020 SHALL implement a scan counter that counts 0..SCAN_DIV-1 and wraps; scan_tick is high in the cycle the count equals SCAN_DIV-1.
REQ-021 SHALL implement a 2-bit digit counter that increments on each scan_tick; frame end is the scan_tick at which the digit counter equals 3.
REQ-022 SHALL, at frame end with pending set, copy shadow to disp_data, clear pending, and set disp_wr_valid; this avoids mid-frame tearing.
REQ-023 SHALL, when a DATA write and frame end fall on the same edge, commit the old shadow, capture the new value into shadow, and leave pending set.
REQ-024 SHALL, on back-to-back DATA writes within one frame, commit only the last value.
REQ-025 SHALL keep the scan and digit counters running regardless of disp_ena.
REQ-026 SHALL make disp_wr_valid sticky, clearing it only by reset.

Reset
REQ-027 SHALL, with rst_n low, force: FSM=IDLE, bus_ack=0, bus_rdata=0, shadow=0, pending=0, disp_data=16'h0000, disp_ena=0, disp_wr_valid=0, and both counters=0.
REQ-028 SHALL, when reset asserts mid-transaction, drop the transaction: no ack is issued after release and the requester must reissue.

Configuration
REQ-029 SHALL provide macro SEG_READBACK_EN; when defined, a DATA read returns {16'h0, disp_data} and a CTRL read returns {29'h0, pending, disp_wr_valid, disp_ena}.
REQ-030 SHALL, without SEG_READBACK_EN, still acknowledge reads on hit addresses with bus_rdata=0.

Structure
REQ-031 SHALL place the FSM state encoding, the CTRL bit positions, and the SEG_BASE default in shared package seg_display_pkg.
REQ-032 SHALL implement the scan and digit counters as sub-module seg_scan_timer (outputs scan_tick and frame_end).

Verification
REQ-033 SHALL verify: reset release, SCAN_DIV=4 -> scan_tick every 4th cycle; disp_data=0000, disp_wr_valid=0.
REQ-034 SHALL verify: write 32'hABCD_1234 to SEG_BASE -> bus_ack 1 cycle later; disp_data=16'h1234 only at the next frame end; disp_wr_valid=1.
REQ-035 SHALL verify: writes 16'h1111 then 16'h2222 within one frame -> only 16'h2222 is committed.
REQ-036 SHALL verify: a DATA write coinciding with frame end -> old shadow is committed, pending stays 1, and the new value is committed at the following frame end.
REQ-037 SHALL verify: a write to SEG_BASE+8 -> no bus_ack and no state change; a CTRL write of 1 -> disp_ena=1 at the ack cycle.
REQ-038 SHALL verify: with SEG_READBACK_EN defined, a read of SEG_BASE+4 after REQ-034 -> bus_rdata=32'h0000_0002 (disp_ena=0); with the macro undefined -> bus_rdata=0.
